// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO feeding an 8-bit UART transmitter (8N1, or 8E1 when
//            UART_TX_PARITY_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_PER_BIT     = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       UART_TX,
  output logic       tx_busy
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0]           BIT_RELOAD = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;

  // Ready depends on the registered count only, so a full FIFO refuses a
  // push even when the serializer pops on the same edge.
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign tx_ready = !full;
  assign push     = tx_valid && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= tx_data;
  end

  // ---------------------------------------------------------- serializer
  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       data_reg, data_nxt;
  logic             tx_q, tx_nxt;
  logic             bit_done;

  assign bit_done = (bit_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      data_reg <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      data_reg <= data_nxt;
      tx_q     <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_done ? BIT_RELOAD : (bit_cnt - CNT_ONE);
    bit_idx_nxt = bit_idx;
    data_nxt    = data_reg;
    tx_nxt      = tx_q;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt      = 1'b1;
        bit_cnt_nxt = '0;
        if (!empty) begin
          pop         = 1'b1;
          data_nxt    = mem[rd_ptr];
          tx_nxt      = 1'b0;
          bit_cnt_nxt = BIT_RELOAD;
          state_nxt   = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = data_reg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = ^data_reg;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = data_reg[bit_idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit so frames run back-to-back.
          if (!empty) begin
            pop       = 1'b1;
            data_nxt  = mem[rd_ptr];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            tx_nxt      = 1'b1;
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  assign UART_TX = tx_q;
  assign tx_busy = (state != IDLE) || !empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// Testbench for uart_tx_fifo: per-cycle reference model of the serial line
// plus table-driven frame vectors and hand-written corner sequences.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NFRAME = 11;
`else
  localparam int NFRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       UART_TX;
  logic       tx_busy;

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .UART_TX  (UART_TX),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: queue of accepted bytes and queue of future line levels.
  logic [7:0] mq[$];
  logic       lq[$];
  logic       e_tx = 1'b1, e_ready = 1'b1, e_busy = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic build_frame(input logic [7:0] b);
    for (int c = 0; c < CPB; c++) lq.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CPB; c++) lq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) lq.push_back(^b);
`endif
    for (int c = 0; c < CPB; c++) lq.push_back(1'b1);
  endtask

  task automatic step();
    logic acc, had;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      lq.delete();
      e_tx   = 1'b1;
      e_busy = 1'b0;
    end else begin
      acc = tx_valid && (mq.size() < DEPTH);
      if (lq.size() == 0 && mq.size() != 0) build_frame(mq.pop_front());
      had = (lq.size() != 0);
      e_tx = had ? lq.pop_front() : 1'b1;
      if (acc) mq.push_back(tx_data);
      e_busy = had || (mq.size() != 0);
    end
    e_ready = (mq.size() < DEPTH);
    #1;
    chk("model_tx", int'(UART_TX), int'(e_tx));
    chk("model_ready", int'(tx_ready), int'(e_ready));
    chk("model_busy", int'(tx_busy), int'(e_busy));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mq.size() != 0 || lq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", int'(n < budget), 1);
    step();
  endtask

  // Wait until the model predicts a pop on the coming edge.
  task automatic wait_pop_edge(input int budget);
    int n = 0;
    while (!(lq.size() == 0 && mq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("pop_edge_in_budget", int'(n < budget), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // stop, d7..d0, start (LSB sent first)
    logic       par;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [10:0] exp_f;
    int nb;
    bit saw_low;

    vecs[0] = '{8'h55, 10'h2AA, 1'b0};
    vecs[1] = '{8'h07, 10'h20E, 1'b1};
    vecs[2] = '{8'hA5, 10'h34A, 1'b0};
    vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[4] = '{8'h00, 10'h200, 1'b0};
    vecs[5] = '{8'h80, 10'h300, 1'b1};
    vecs[6] = '{8'h01, 10'h202, 1'b1};

    // Reset, then reset again mid-idle for three cycles
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_tx", int'(UART_TX), 1);
    chk("reset_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(tx_busy), 0);
    step();

    // Single-frame table vectors
    foreach (vecs[v]) begin
`ifdef UART_TX_PARITY_EN
      exp_f = {vecs[v].frame[9], vecs[v].par, vecs[v].frame[8:0]};
`else
      exp_f = {1'b0, vecs[v].frame};
`endif
      tx_data  = vecs[v].data;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      for (int k = 0; k < NFRAME; k++)
        for (int c = 0; c < CPB; c++) begin
          step();
          chk($sformatf("tbl%0d_bit%0d", v, k), int'(UART_TX), int'(exp_f[k]));
        end
      chk("tbl_busy_last_cycle", int'(tx_busy), 1);
      step();
      chk("tbl_busy_after", int'(tx_busy), 0);
      chk("tbl_tx_after", int'(UART_TX), 1);
      repeat (2) step();
    end

    // Hold valid with 0x00..0x13: FIFO fills, then drains back-to-back
    nb = 0;
    saw_low = 0;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    for (int n = 0; n < 2000 && nb < 20; n++) begin
      bit acc;
      acc = (mq.size() < DEPTH);
      step();
      if (!tx_ready) saw_low = 1;
      if (acc) begin
        nb++;
        tx_data = 8'(nb);
        if (nb == 20) tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    chk("fill_all_accepted", nb, 20);
    chk("fill_ready_fell", int'(saw_low), 1);
    drain(20 * NFRAME * CPB + 100);
    chk("fill_busy_after", int'(tx_busy), 0);

    // Reset 10 cycles into a frame of 0xA5 with 3 bytes queued
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    step();
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'h10 + 8'(i);
      step();
    end
    tx_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_tx", int'(UART_TX), 1);
    chk("abort_busy", int'(tx_busy), 0);
    chk("abort_ready", int'(tx_ready), 1);
    for (int i = 0; i < 60; i++) begin
      step();
      chk("abort_line_idle", int'(UART_TX), 1);
    end

    // Push at count 15 and 16 on a pop edge
    tx_valid = 1'b1;
    for (int n = 0; n < 100 && mq.size() < 15; n++) begin
      tx_data = 8'($urandom);
      step();
    end
    tx_valid = 1'b0;
    wait_pop_edge(200);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    step();
    tx_valid = 1'b0;
    chk("cnt15_pushpop_ready", int'(tx_ready), 1);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    step();
    tx_valid = 1'b0;
    chk("cnt16_full", int'(tx_ready), 0);
    wait_pop_edge(200);
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    step();
    tx_valid = 1'b0;
    chk("cnt16_pushpop_refused_ready", int'(tx_ready), 1);
    drain(17 * NFRAME * CPB + 100);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      tx_valid = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 8 : 60));
      tx_data  = 8'($urandom);
      rst      = ($urandom_range(0, 699) == 0);
      step();
    end
    rst = 1'b0;
    tx_valid = 1'b0;
    drain(17 * NFRAME * CPB + 100);
    chk("final_busy", int'(tx_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
